// File: rtl/lcd_pixel_prefetch_if.sv
// Bus bundle between the pixel prefetch buffer, the frame-buffer reader
// and the LCD stage.
//
// Ports carried:
//   en, frame_start          control from the display timing logic
//   burst_req / burst_ack    burst request handshake to the reader
//   wr_en / wr_data          burst pixel stream from the reader (RGB565)
//   pixel_en / pixel_data    pixel strobe from the LCD stage and the returned pixel
//   fifo_level               occupancy, 0..2**AW
//   underflow / overflow     sticky error flags
//   dbg_state                burst FSM state (0 IDLE, 1 REQ, 2 FILL, 3 DRAIN)
//
// Handshake rules: burst_req is a level that stays high until the reader
// pulses burst_ack in a cycle where burst_req is high; the request is
// consumed at that clock edge. After the ack the reader pushes exactly
// BURST_LEN pixels, one per cycle in which wr_en is high (wr_en has no
// back-pressure; gaps are allowed). pixel_en is a single-cycle strobe and
// pixel_data answers it on the following cycle.
interface lcd_pixel_prefetch_if #(
  parameter int AW = 9
);
  logic          en;
  logic          frame_start;
  logic          burst_req;
  logic          burst_ack;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          pixel_en;
  logic [15:0]   pixel_data;
  logic [AW:0]   fifo_level;
  logic          underflow;
  logic          overflow;
  logic [1:0]    dbg_state;

  // The prefetch buffer itself.
  modport slave (
    input  en, frame_start, burst_ack, wr_en, wr_data, pixel_en,
    output burst_req, pixel_data, fifo_level, underflow, overflow, dbg_state
  );

  // The environment: reader plus LCD stage plus timing control.
  modport master (
    output en, frame_start, burst_ack, wr_en, wr_data, pixel_en,
    input  burst_req, pixel_data, fifo_level, underflow, overflow, dbg_state
  );
endinterface

// File: rtl/lcd_pixel_prefetch.sv
// Pixel prefetch buffer in front of the LCD driver stage. Requests
// fixed-length bursts of RGB565 pixels from the frame-buffer reader, stores
// them in a DEPTH-entry FIFO and hands out one pixel per pixel_en strobe.
// When the FIFO is empty it returns FILL_COLOR and sets a sticky underflow.
//
// Ports:
//   clk    pixel clock (same as the LCD driver stage)
//   rst_n  asynchronous active-low reset
//   bus    lcd_pixel_prefetch_if.slave (see the interface file for signals)
module lcd_pixel_prefetch #(
  parameter int          DEPTH      = 512,
  parameter int          AW         = 9,
  parameter int          BURST_LEN  = 128,
  parameter logic [15:0] FILL_COLOR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_pixel_prefetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FILL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_L = (AW+1)'(BURST_LEN);
  // A new burst is only requested when a whole burst is guaranteed to fit.
  localparam logic [AW:0] LOW_WM  = (AW+1)'(DEPTH - BURST_LEN);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          flush_q, flush_d;       // frame_start seen while in REQ
  logic          burst_req_q, burst_req_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   mem_q [DEPTH];

  logic empty, full, rd_fire, pop, push, drop_err, ack;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == DEPTH_L);
    rd_fire  = bus.pixel_en && !bus.frame_start;
    pop      = rd_fire && !empty;
    push     = bus.wr_en && !bus.frame_start && (state_q == S_FILL) && !full;
    // DRAIN discards silently; only unsolicited or overflowing writes are errors.
    drop_err = bus.wr_en && !bus.frame_start &&
               ((state_q == S_IDLE) || (state_q == S_REQ) ||
                ((state_q == S_FILL) && full));
    ack      = bus.burst_ack && burst_req_q;
  end

  // Datapath: pointers, level, output pixel and sticky flags.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    pixel_d     = pixel_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (bus.frame_start) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (pop)                 pixel_d = mem_q[rd_ptr_q];
      else if (rd_fire)        pixel_d = FILL_COLOR;
      if (rd_fire && empty)    underflow_d = 1'b1;
      if (drop_err)            overflow_d  = 1'b1;
    end
  end

  // Burst FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    burst_req_d = burst_req_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.frame_start && bus.en && (level_q <= LOW_WM)) state_d = S_REQ;
      end
      S_REQ: begin
        burst_req_d = 1'b1;
        if (bus.frame_start) flush_d = 1'b1;
        if (ack) begin
          burst_req_d = 1'b0;
          cnt_d       = BURST_L;
          // The reader still delivers a flushed burst; it is drained.
          state_d     = (flush_q || bus.frame_start) ? S_DRAIN : S_FILL;
          flush_d     = 1'b0;
        end
      end
      S_FILL, S_DRAIN: begin
        if (bus.frame_start) state_d = S_DRAIN;
        if (bus.wr_en) begin
          cnt_d = cnt_q - (AW+1)'(1);
          if (cnt_q == (AW+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      burst_req_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      burst_req_q <= burst_req_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.burst_req  = burst_req_q;
  assign bus.pixel_data = pixel_q;
  assign bus.fifo_level = level_q;
  assign bus.underflow  = underflow_q;
  assign bus.overflow   = overflow_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_pixel_prefetch.sv
module tb_lcd_pixel_prefetch;
  localparam int          DEPTH = 512;
  localparam int          AW    = 9;
  localparam int          BL    = 128;
  localparam logic [15:0] FILL  = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_pixel_prefetch_if #(.AW(AW)) bus();

  lcd_pixel_prefetch #(
    .DEPTH(DEPTH), .AW(AW), .BURST_LEN(BL), .FILL_COLOR(FILL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];   // expected pixel_data answers, one per accepted strobe
  logic [15:0] m_q[$];     // model FIFO contents
  bit          m_uf, m_of, m_doomed;
  bit          mon_on;

  // Stimulus controls and reader agent state.
  bit          tb_en, tb_pix_en, tb_fs, tb_wr_err, ag_on;
  int          ag_phase, ag_dly, ag_left, ag_sent, ag_bursts, ag_ack_dly, ag_gap_pct;
  logic [15:0] ag_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: the reader agent decides its outputs, inputs are
  // applied, the model is advanced by the rules of the FIFO, then time moves
  // to just after the next rising edge.
  task automatic step();
    bit          outst, last_wr, doing_wr, full_now;
    logic [15:0] wd;
    outst    = bus.burst_req || (ag_phase != 0);
    last_wr  = 0;
    doing_wr = 0;
    wd       = 16'($urandom);
    bus.burst_ack = 1'b0;
    case (ag_phase)
      0: if (ag_on && bus.burst_req) begin
           ag_phase = 1;
           ag_dly   = (ag_ack_dly < 0) ? int'($urandom_range(0, 3)) : ag_ack_dly;
         end
      1: if (ag_dly == 0) begin
           bus.burst_ack = 1'b1;
           ag_phase = 2; ag_left = BL; ag_sent = 0;
         end else ag_dly--;
      2: if (int'($urandom_range(0, 99)) >= ag_gap_pct) begin
           doing_wr = 1; wd = ag_val; ag_val++;
           ag_left--; ag_sent++;
           if (ag_left == 0) begin ag_phase = 0; last_wr = 1; ag_bursts++; end
         end
      default: ag_phase = 0;
    endcase
    if (tb_wr_err) begin doing_wr = 1; wd = 16'hABCD; end
    bus.wr_en       = doing_wr;
    bus.wr_data     = wd;
    bus.en          = tb_en;
    bus.frame_start = tb_fs;
    bus.pixel_en    = tb_pix_en;

    full_now = (m_q.size() == DEPTH);
    if (tb_fs) begin
      m_q.delete(); m_uf = 0; m_of = 0;
    end else begin
      if (tb_pix_en) begin
        if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
        else begin exp_q.push_back(FILL); m_uf = 1; end
      end
      if (doing_wr) begin
        if (tb_wr_err) m_of = 1;
        else if (!m_doomed) begin
          if (full_now) m_of = 1; else m_q.push_back(wd);
        end
      end
    end
    if (last_wr) m_doomed = 0;
    if (tb_fs && outst && !last_wr) m_doomed = 1;

    @(posedge clk);
    #1;
    tb_fs = 0;
    tb_wr_err = 0;
  endtask

  task automatic wait_bursts(input int target, input int budget, input string name);
    int n = 0;
    while (ag_bursts < target && n < budget) begin step(); n++; end
    chk(name, 32'(ag_bursts >= target), 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin step(); n++; seen = bus.burst_req; end
    chk(name, 32'(seen), 1);
  endtask

  task automatic idle_no_req(input int cycles, input string name);
    bit seen = 0;
    repeat (cycles) begin step(); if (bus.burst_req) seen = 1; end
    chk(name, 32'(seen), 0);
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 2000) begin
      step(); n++;
      if (ag_phase == 0 && !bus.burst_req) quiet++; else quiet = 0;
    end
    chk("settle_timeout", 32'(quiet >= 3), 1);
  endtask

  task automatic drain();
    int n = 0;
    tb_pix_en = 1;
    while (m_q.size() > 0 && n < 2000) begin step(); n++; end
    tb_pix_en = 0;
    step();
    chk("drain_level", 32'(bus.fifo_level), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit          fire, act, e_uf, e_of;
    int          e_lvl;
    logic [15:0] e_pix;
    forever begin
      @(posedge clk);
      act   = mon_on;
      fire  = mon_on && bus.pixel_en && !bus.frame_start;
      e_lvl = m_q.size();
      e_uf  = m_uf;
      e_of  = m_of;
      @(negedge clk);
      if (act) begin
        chk("fifo_level", 32'(bus.fifo_level), 32'(e_lvl));
        chk("underflow", 32'(bus.underflow), 32'(e_uf));
        chk("overflow", 32'(bus.overflow), 32'(e_of));
      end
      if (fire) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pixel_data: strobe with no expected entry at %0t", $time);
        end else begin
          e_pix = exp_q.pop_front();
          chk("pixel_data", 32'(bus.pixel_data), 32'(e_pix));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    int b0;
    bus.en = 0; bus.frame_start = 0; bus.burst_ack = 0; bus.wr_en = 0;
    bus.wr_data = 0; bus.pixel_en = 0;
    tb_en = 0; tb_pix_en = 0; tb_fs = 0; tb_wr_err = 0; ag_on = 0;
    ag_phase = 0; ag_dly = 0; ag_left = 0; ag_sent = 0; ag_bursts = 0;
    ag_ack_dly = 1; ag_gap_pct = 0; ag_val = 0;
    m_uf = 0; m_of = 0; m_doomed = 0; mon_on = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixel_data", 32'(bus.pixel_data), 0);
    chk("rst_burst_req", 32'(bus.burst_req), 0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    mon_on = 1;

    // Basic fill: ack in the 3rd request cycle, 128 back-to-back writes 0..127.
    ag_on = 1; ag_ack_dly = 1; ag_gap_pct = 0; ag_val = 0; tb_en = 1;
    lat = 0;
    do begin step(); lat++; end while (!bus.burst_req && lat < 10);
    chk("req_latency", 32'(lat), 2);
    wait_bursts(1, 400, "burst1_timeout");
    chk("level_after_burst", 32'(bus.fifo_level), 128);
    ag_on = 0;
    wait_req(4, "rerequest_after_burst");
    tb_en = 0; ag_on = 1;
    wait_bursts(2, 400, "burst2_timeout");
    idle_no_req(10, "no_req_when_disabled");

    // Ordered readout of 0..255.
    tb_pix_en = 1;
    repeat (256) step();
    tb_pix_en = 0;
    repeat (2) step();
    chk("level_after_readout", 32'(bus.fifo_level), 0);

    // Underflow on empty FIFO, sticky until frame_start.
    tb_pix_en = 1;
    repeat (3) step();
    tb_pix_en = 0;
    repeat (5) step();
    chk("underflow_sticky", 32'(bus.underflow), 1);
    tb_fs = 1;
    step();
    chk("underflow_cleared", 32'(bus.underflow), 0);

    // Wrap and watermark with random data, ack delays and write gaps.
    ag_ack_dly = -1; ag_gap_pct = 30; ag_val = 16'($urandom); tb_en = 1;
    b0 = ag_bursts;
    wait_bursts(b0 + 4, 4000, "fill_to_full_timeout");
    chk("level_full", 32'(bus.fifo_level), DEPTH);
    idle_no_req(20, "no_req_when_full");
    tb_pix_en = 1;
    repeat (128) step();
    tb_pix_en = 0;
    chk("level_after_128_reads", 32'(bus.fifo_level), DEPTH - BL);
    wait_req(4, "req_at_watermark");
    repeat (1500) begin
      tb_pix_en = (int'($urandom_range(0, 99)) < 60);
      step();
    end
    tb_pix_en = 0; tb_en = 0;
    settle();
    drain();

    // Flush after 50 of 128 writes: remaining writes drained, then a new request.
    tb_fs = 1;
    step();
    tb_en = 1; ag_gap_pct = 20;
    lat = 0;
    while (!(ag_phase == 2 && ag_sent == 50) && lat < 2000) begin step(); lat++; end
    chk("flush_point_timeout", 32'(ag_sent), 50);
    b0 = ag_bursts;
    tb_fs = 1;
    step();
    wait_bursts(b0 + 1, 1000, "drain_timeout");
    chk("flush_level", 32'(bus.fifo_level), 0);
    chk("flush_overflow", 32'(bus.overflow), 0);
    wait_req(4, "req_after_drain");
    tb_en = 0;
    wait_bursts(b0 + 2, 1000, "post_flush_burst_timeout");
    chk("level_post_flush_burst", 32'(bus.fifo_level), 128);

    // Protocol error: write while no burst is granted.
    repeat (3) step();
    tb_wr_err = 1;
    step();
    chk("protocol_err_overflow", 32'(bus.overflow), 1);
    chk("protocol_err_level", 32'(bus.fifo_level), 128);

    // Flush while a request is pending: the acked burst is drained.
    tb_en = 1; ag_on = 0;
    wait_req(4, "req_for_req_flush");
    step();
    tb_fs = 1;
    step();
    tb_en = 0; ag_on = 1;
    b0 = ag_bursts;
    wait_bursts(b0 + 1, 1000, "req_flush_drain_timeout");
    repeat (3) step();
    chk("req_flush_level", 32'(bus.fifo_level), 0);
    chk("req_flush_overflow", 32'(bus.overflow), 0);
    idle_no_req(5, "no_req_after_req_flush");

    repeat (2) step();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
